// File: rtl/wb_sdram_traffic_gen.sv
// wb_sdram_traffic_gen: Wishbone master traffic generator for the sdrc_top slave.
// Issues bursts of LFSR-patterned writes, reads, or write-then-readback-verify
// once SDRAM initialisation completes, and reports busy/done/timeout/error count.
//
// Ports:
//   sys_clk, RESETN           clock, asynchronous active-low reset
//   start, mode, base_addr,   run launch pulse and run configuration
//   burst_len, num_bursts     (sampled on start)
//   sdr_init_done             SDRAM controller ready
//   wb_*                      Wishbone master interface
//   busy, done, timeout       run status
//   err_cnt                   readback mismatch count (saturating)
//   first_err_*               first-mismatch log
//
// Optional feature: define TGEN_ERR_LOG_EN to build the first-error capture
// registers; otherwise first_err_* are tied to zero.
module wb_sdram_traffic_gen #(
    parameter int unsigned DW          = 32,
    parameter int unsigned AW          = 26,
    parameter int unsigned SEL_W       = DW / 8,
    parameter int unsigned BURST_MAX   = 8,
    parameter logic [31:0] LFSR_SEED   = 32'hACE1_2468,
    parameter int unsigned TIMEOUT     = 1024
) (
    input  logic             sys_clk,
    input  logic             RESETN,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [AW-1:0]    base_addr,
    input  logic [4:0]       burst_len,
    input  logic [7:0]       num_bursts,
    input  logic             sdr_init_done,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [AW-1:0]    wb_addr_o,
    output logic [DW-1:0]    wb_dat_o,
    output logic [SEL_W-1:0] wb_sel_o,
    input  logic             wb_ack_i,
    input  logic [DW-1:0]    wb_dat_i,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [15:0]      err_cnt,
    output logic [AW-1:0]    first_err_addr,
    output logic [DW-1:0]    first_err_exp,
    output logic [DW-1:0]    first_err_got
);

    localparam int unsigned WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;   // x^32+x^22+x^2+x+1, right-shift Galois
    localparam logic [4:0]  BMAX      = 5'(BURST_MAX);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_INIT, S_XFER, S_GAP, S_SWITCH, S_FINISH
    } state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

    state_t            state_q, state_d;
    logic              verify_q, verify_d;
    logic              rd_q, rd_d;
    logic [AW-1:0]     base_q, base_d;
    logic [4:0]        blen_q, blen_d;
    logic [7:0]        nburst_q, nburst_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [31:0]       lfsr_q, lfsr_d;
    logic [4:0]        beat_q, beat_d;
    logic [7:0]        burst_q, burst_d;
    logic [WD_W-1:0]   wdog_q, wdog_d;
    logic              stb_q, stb_d;
    logic              we_q, we_d;
    logic [DW-1:0]     dat_q, dat_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              tmo_q, tmo_d;
    logic [15:0]       err_q, err_d;

    logic [4:0]        blen_clamp_c;
    logic              beat_ok_c;
    logic              mismatch_c;

    // Zero means one beat; anything above BURST_MAX is clamped.
    assign blen_clamp_c = (burst_len == 5'd0) ? 5'd1 :
                          (burst_len > BMAX)  ? BMAX : burst_len;
    assign beat_ok_c    = stb_q & wb_ack_i;
    assign mismatch_c   = beat_ok_c & rd_q & verify_q & (wb_dat_i != lfsr_q[DW-1:0]);

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        verify_d = verify_q;
        rd_d     = rd_q;
        base_d   = base_q;
        blen_d   = blen_q;
        nburst_d = nburst_q;
        addr_d   = addr_q;
        lfsr_d   = lfsr_q;
        beat_d   = beat_q;
        burst_d  = burst_q;
        wdog_d   = wdog_q;
        tmo_d    = tmo_q;
        err_d    = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_WAIT_INIT;
                    verify_d = mode[1];
                    rd_d     = (mode == 2'd1);
                    base_d   = base_addr;
                    blen_d   = blen_clamp_c;
                    nburst_d = num_bursts;
                    addr_d   = base_addr;
                    lfsr_d   = LFSR_SEED;
                    beat_d   = 5'd0;
                    burst_d  = 8'd0;
                    wdog_d   = '0;
                    tmo_d    = 1'b0;
                    err_d    = 16'd0;
                end
            end
            S_WAIT_INIT: begin
                if (sdr_init_done) begin
                    state_d = (nburst_q == 8'd0) ? S_FINISH : S_XFER;
                end
            end
            S_XFER: begin
                if (beat_ok_c) begin
                    addr_d = addr_q + AW'(1);
                    lfsr_d = lfsr_step(lfsr_q);
                    beat_d = beat_q + 5'd1;
                    wdog_d = '0;
                    if (mismatch_c && err_q != 16'hFFFF) begin
                        err_d = err_q + 16'd1;
                    end
                    if (beat_q == blen_q - 5'd1) begin
                        beat_d  = 5'd0;
                        burst_d = burst_q + 8'd1;
                        state_d = S_GAP;
                    end
                end else if (wdog_q == WD_W'(TIMEOUT - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = S_FINISH;
                end else begin
                    wdog_d = wdog_q + WD_W'(1);
                end
            end
            S_GAP: begin
                if (burst_q != nburst_q) begin
                    state_d = S_XFER;
                end else if (verify_q && !rd_q) begin
                    state_d = S_SWITCH;
                end else begin
                    state_d = S_FINISH;
                end
            end
            S_SWITCH: begin
                addr_d  = base_q;
                lfsr_d  = LFSR_SEED;
                rd_d    = 1'b1;
                burst_d = 8'd0;
                beat_d  = 5'd0;
                wdog_d  = '0;
                state_d = S_XFER;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Bus outputs are registered against the state being entered.
        stb_d  = (state_d == S_XFER);
        we_d   = stb_d & ~rd_d;
        dat_d  = stb_d ? lfsr_d[DW-1:0] : '0;
        sel_d  = stb_d ? '1 : '0;
        busy_d = (state_d != S_IDLE) && (state_d != S_FINISH);
        done_d = (state_d == S_FINISH);
    end

    // State and output registers.
    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            state_q  <= S_IDLE;
            verify_q <= 1'b0;
            rd_q     <= 1'b0;
            base_q   <= '0;
            blen_q   <= 5'd0;
            nburst_q <= 8'd0;
            addr_q   <= '0;
            lfsr_q   <= LFSR_SEED;
            beat_q   <= 5'd0;
            burst_q  <= 8'd0;
            wdog_q   <= '0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            dat_q    <= '0;
            sel_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tmo_q    <= 1'b0;
            err_q    <= 16'd0;
        end else begin
            state_q  <= state_d;
            verify_q <= verify_d;
            rd_q     <= rd_d;
            base_q   <= base_d;
            blen_q   <= blen_d;
            nburst_q <= nburst_d;
            addr_q   <= addr_d;
            lfsr_q   <= lfsr_d;
            beat_q   <= beat_d;
            burst_q  <= burst_d;
            wdog_q   <= wdog_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            tmo_q    <= tmo_d;
            err_q    <= err_d;
        end
    end

    assign wb_cyc_o  = stb_q;
    assign wb_stb_o  = stb_q;
    assign wb_we_o   = we_q;
    assign wb_addr_o = addr_q;
    assign wb_dat_o  = dat_q;
    assign wb_sel_o  = sel_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = tmo_q;
    assign err_cnt   = err_q;

`ifdef TGEN_ERR_LOG_EN
    logic [AW-1:0] fe_addr_q, fe_addr_d;
    logic [DW-1:0] fe_exp_q, fe_exp_d;
    logic [DW-1:0] fe_got_q, fe_got_d;

    // Capture only the first mismatch of a run; cleared when a run starts.
    always_comb begin
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;
        if (state_q == S_IDLE && start) begin
            fe_addr_d = '0;
            fe_exp_d  = '0;
            fe_got_d  = '0;
        end else if (mismatch_c && err_q == 16'd0) begin
            fe_addr_d = addr_q;
            fe_exp_d  = lfsr_q[DW-1:0];
            fe_got_d  = wb_dat_i;
        end
    end

    always_ff @(posedge sys_clk or negedge RESETN) begin
        if (!RESETN) begin
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;
`else
    assign first_err_addr = '0;
    assign first_err_exp  = '0;
    assign first_err_got  = '0;
`endif

endmodule

// File: tb/tb_wb_sdram_traffic_gen.sv
// Directed testbench for wb_sdram_traffic_gen with a beat scoreboard and a
// simple Wishbone slave model backed by a small memory.
module tb_wb_sdram_traffic_gen;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 26;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic          sys_clk = 1'b0;
    logic          RESETN;
    logic          start;
    logic [1:0]    mode;
    logic [AW-1:0] base_addr;
    logic [4:0]    burst_len;
    logic [7:0]    num_bursts;
    logic          sdr_init_done;
    logic          wb_cyc_o, wb_stb_o, wb_we_o;
    logic [AW-1:0] wb_addr_o;
    logic [DW-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_ack_i;
    logic [DW-1:0] wb_dat_i;
    logic          busy, done, timeout;
    logic [15:0]   err_cnt;
    logic [AW-1:0] first_err_addr;
    logic [DW-1:0] first_err_exp, first_err_got;

    wb_sdram_traffic_gen dut (
        .sys_clk(sys_clk), .RESETN(RESETN), .start(start), .mode(mode),
        .base_addr(base_addr), .burst_len(burst_len), .num_bursts(num_bursts),
        .sdr_init_done(sdr_init_done), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o),
        .wb_sel_o(wb_sel_o), .wb_ack_i(wb_ack_i), .wb_dat_i(wb_dat_i),
        .busy(busy), .done(done), .timeout(timeout), .err_cnt(err_cnt),
        .first_err_addr(first_err_addr), .first_err_exp(first_err_exp),
        .first_err_got(first_err_got)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          we;
    } beat_t;

    beat_t         exp_q[$];
    beat_t         mon_e;
    int unsigned   beat_cyc[$];
    int unsigned   cyc_n = 0;
    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            stb_hi_cnt = 0;
    int            rd_idx = 0;
    int            corrupt_idx = -1;
    logic          cyc_seen = 1'b0;
    logic          ack_en = 1'b0;
    logic          ack_force = 1'b0;
    logic [DW-1:0] mem [16];

    assign wb_ack_i = ack_force | (ack_en & wb_stb_o);
    assign wb_dat_i = mem[wb_addr_o[3:0]] ^ ((rd_idx == corrupt_idx) ? 32'h1 : 32'h0);

    always @(posedge sys_clk) cyc_n <= cyc_n + 1;

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Scoreboard side: every acknowledged beat is matched against the queue.
    always @(negedge sys_clk) begin
        if (done === 1'b1) done_cnt++;
        if (wb_stb_o === 1'b1) stb_hi_cnt++;
        if (wb_cyc_o === 1'b1) cyc_seen = 1'b1;
        if (wb_stb_o === 1'b1 && wb_ack_i === 1'b1) begin
            beat_cyc.push_back(cyc_n);
            chk("beat_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("beat_addr", 64'(wb_addr_o), 64'(mon_e.addr));
                chk("beat_we", 64'(wb_we_o), 64'(mon_e.we));
                chk("beat_sel", 64'(wb_sel_o), 64'hF);
                if (mon_e.we) begin
                    chk("beat_wdata", 64'(wb_dat_o), 64'(mon_e.data));
                    mem[wb_addr_o[3:0]] = wb_dat_o;
                end else begin
                    rd_idx++;
                end
            end
        end
    end

    task automatic push_phase(input logic [AW-1:0] b, input int eb, input int nb, input logic we);
        logic [AW-1:0] a = b;
        logic [31:0]   l = SEED;
        for (int i = 0; i < nb * eb; i++) begin
            exp_q.push_back('{addr: a, data: l[DW-1:0], we: we});
            a = a + AW'(1);
            l = lfsr_next(l);
        end
    endtask

    task automatic run_start(input logic [1:0] m, input logic [AW-1:0] b,
                             input logic [4:0] bl, input logic [7:0] nb, input bit expect_beats);
        int eb = (bl == 0) ? 1 : ((bl > 8) ? 8 : int'(bl));
        if (expect_beats) begin
            if (m != 2'd1) push_phase(b, eb, int'(nb), 1'b1);
            if (m != 2'd0) push_phase(b, eb, int'(nb), 1'b0);
        end
        mode = m; base_addr = b; burst_len = bl; num_bursts = nb;
        beat_cyc.delete();
        rd_idx = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
        @(negedge sys_clk);
        chk({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [31:0] l3;
        int n;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        RESETN = 1'b0; start = 1'b0; mode = 2'd0; base_addr = '0;
        burst_len = 5'd0; num_bursts = 8'd0; sdr_init_done = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("rst_stb", 64'(wb_stb_o), 64'd0);
        chk("rst_we", 64'(wb_we_o), 64'd0);
        chk("rst_addr", 64'(wb_addr_o), 64'd0);
        chk("rst_dat", 64'(wb_dat_o), 64'd0);
        chk("rst_sel", 64'(wb_sel_o), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_timeout", 64'(timeout), 64'd0);
        chk("rst_err", 64'(err_cnt), 64'd0);
        chk("rst_ferr_addr", 64'(first_err_addr), 64'd0);
        RESETN = 1'b1;
        @(negedge sys_clk);

        // Write-then-verify, acked every cycle.
        ack_en = 1'b1;
        run_start(2'd2, 26'h100, 5'd4, 8'd2, 1'b1);
        chk("A_busy", 64'(busy), 64'd1);
        wait_done("A", 100);
        chk("A_nbeats", 64'(beat_cyc.size()), 64'd16);
        chk("A_burst_b2b", 64'(beat_cyc[3] - beat_cyc[0]), 64'd3);
        chk("A_gap", 64'(beat_cyc[4] - beat_cyc[3]), 64'd2);
        chk("A_err", 64'(err_cnt), 64'd0);

        // Same run with read beat 3 corrupted.
        corrupt_idx = 3;
        run_start(2'd2, 26'h100, 5'd4, 8'd2, 1'b1);
        wait_done("B", 100);
        chk("B_err", 64'(err_cnt), 64'd1);
        l3 = SEED;
        for (int i = 0; i < 3; i++) l3 = lfsr_next(l3);
`ifdef TGEN_ERR_LOG_EN
        chk("B_ferr_addr", 64'(first_err_addr), 64'h103);
        chk("B_ferr_exp", 64'(first_err_exp), 64'(l3));
        chk("B_ferr_got", 64'(first_err_got), 64'(l3 ^ 32'h1));
`else
        chk("B_ferr_addr", 64'(first_err_addr), 64'd0);
        chk("B_ferr_exp", 64'(first_err_exp), 64'd0);
        chk("B_ferr_got", 64'(first_err_got), 64'd0);
`endif
        corrupt_idx = -1;

        // Held off by sdr_init_done; spurious acks while idle must be ignored.
        sdr_init_done = 1'b0;
        run_start(2'd0, 26'h100, 5'd2, 8'd1, 1'b1);
        chk("C_err_cleared", 64'(err_cnt), 64'd0);
        chk("C_ferr_cleared", 64'(first_err_addr), 64'd0);
        cyc_seen = 1'b0;
        ack_force = 1'b1;
        repeat (500) @(negedge sys_clk);
        chk("C_busy_hold", 64'(busy), 64'd1);
        chk("C_no_cyc", 64'(cyc_seen), 64'd0);
        ack_force = 1'b0;
        sdr_init_done = 1'b1;
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 2) begin
            @(negedge sys_clk);
            n++;
        end
        chk("C_first_write_latency", 64'(wb_stb_o), 64'd1);
        wait_done("C", 20);

        // Slave never acks: watchdog expiry.
        ack_en = 1'b0;
        run_start(2'd0, 26'h100, 5'd4, 8'd1, 1'b0);
        stb_hi_cnt = 0;
        wait_done("D", 1200);
        chk("D_stb_cycles", 64'(stb_hi_cnt), 64'd1024);
        chk("D_timeout", 64'(timeout), 64'd1);
        chk("D_err", 64'(err_cnt), 64'd0);
        chk("D_cyc_low", 64'(wb_cyc_o), 64'd0);
        ack_en = 1'b1;

        // Address wrap; a start pulse mid-run is ignored.
        run_start(2'd0, 26'h3FF_FFFE, 5'd4, 8'd1, 1'b1);
        chk("E_timeout_cleared", 64'(timeout), 64'd0);
        repeat (2) @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        wait_done("E", 40);
        chk("E_nbeats", 64'(beat_cyc.size()), 64'd4);

        // burst_len 0 gives a single beat.
        run_start(2'd0, 26'h100, 5'd0, 8'd1, 1'b1);
        wait_done("F", 40);
        chk("F_nbeats", 64'(beat_cyc.size()), 64'd1);

        // Read-only, clamped burst; corrupted data must not count.
        corrupt_idx = 0;
        run_start(2'd1, 26'h100, 5'd20, 8'd1, 1'b1);
        wait_done("G", 40);
        chk("G_nbeats", 64'(beat_cyc.size()), 64'd8);
        chk("G_err", 64'(err_cnt), 64'd0);
        corrupt_idx = -1;

        // No bursts: straight to done.
        run_start(2'd2, 26'h100, 5'd4, 8'd0, 1'b1);
        wait_done("H", 20);
        chk("H_nbeats", 64'(beat_cyc.size()), 64'd0);

        // Reset mid-burst, then seed data on the first beat of a new run.
        run_start(2'd0, 26'h100, 5'd8, 8'd2, 1'b1);
        repeat (3) @(negedge sys_clk);
        chk("I_midburst_stb", 64'(wb_stb_o), 64'd1);
        #2 RESETN = 1'b0;
        #1;
        chk("I_rst_cyc", 64'(wb_cyc_o), 64'd0);
        chk("I_rst_stb", 64'(wb_stb_o), 64'd0);
        chk("I_rst_busy", 64'(busy), 64'd0);
        exp_q.delete();
        @(negedge sys_clk);
        RESETN = 1'b1;
        @(negedge sys_clk);
        run_start(2'd0, 26'h100, 5'd1, 8'd1, 1'b1);
        n = 0;
        while (wb_stb_o !== 1'b1 && n < 4) begin
            @(negedge sys_clk);
            n++;
        end
        chk("I_seed_data", 64'(wb_dat_o), 64'h00000000ACE12468);
        wait_done("I", 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_sdram_traffic_gen.md
Name: wb_sdram_traffic_gen

Overview:
Synthesizable Wishbone master stimulus engine for the emulation-side top, driving the sdrc_top Wishbone slave port.
Issues parametrised bursts of LFSR-patterned writes, reads, or write-then-readback-verify, starting once SDRAM init completes.
Reports busy/done, error count, ack timeout and, optionally, a first-error log.
Successor to fixed static Wishbone stimulus: generalised in data width, address width, burst length, burst count and mode.

Parameters:
DW, 32, Wishbone data width; legal values 8, 16, 32
AW, 26, Wishbone word-address width
SEL_W, DW/8, byte-select width
BURST_MAX, 8, maximum beats per burst; power of 2, ≤16
LFSR_SEED, 32'hACE1_2468, LFSR reload value; must be nonzero
TIMEOUT, 1024, ack watchdog limit in cycles

Ports:
sys_clk  in  1  system clock; all logic on the rising edge
RESETN  in  1  asynchronous active-low reset
start  in  1  1-cycle pulse that launches a run; ignored while busy=1
mode  in  2  0=write only, 1=read only, 2=write then readback verify, 3=reserved (treated as 2)
base_addr  in  AW  first word address
burst_len  in  5  beats per burst; 0 treated as 1; values >BURST_MAX clamp to BURST_MAX
num_bursts  in  8  bursts per phase
sdr_init_done  in  1  SDRAM controller initialisation complete
wb_cyc_o / wb_stb_o / wb_we_o  out  1 each  Wishbone master controls
wb_addr_o  out  AW  word address
wb_dat_o  out  DW  write data
wb_sel_o  out  SEL_W  byte selects; all ones
wb_ack_i  in  1  slave ack
wb_dat_i  in  DW  read data
busy  out  1  run in progress
done  out  1  1-cycle pulse at run end
timeout  out  1  sticky; set on ack watchdog expiry, cleared by start
err_cnt  out  16  readback mismatches; saturates at 16'hFFFF
first_err_addr / first_err_exp / first_err_got  out  AW / DW / DW  first-error log (optional feature)

Behaviour:
- Reset values: all outputs 0; lfsr=LFSR_SEED; FSM=IDLE.
- Start sampling: mode, base_addr, burst_len and num_bursts are latched on start. On the same start, err_cnt and timeout are cleared. busy=1 from the next cycle.
- FSM states: IDLE, WAIT_INIT, XFER, GAP, SWITCH, FINISH.
- IDLE: waits for start.
- WAIT_INIT: holds until sdr_init_done=1. If sdr_init_done is already high, WAIT_INIT lasts 1 cycle.
- XFER: cyc=stb=1; we=1 in the write phase, 0 in the read phase.
  - A beat completes on a cycle with stb&ack.
  - On beat completion: addr+1 (wraps modulo 2^AW), lfsr advances, beat counter increments.
  - The next beat is presented the cycle after ack; stb stays high across the burst.
- GAP: entered after the last beat of a burst; cyc=stb=0 for exactly 1 cycle. Then:
  - next burst → XFER;
  - bursts exhausted, mode=2, write phase → SWITCH;
  - otherwise → FINISH.
- SWITCH: 1 cycle. Reloads addr=base_addr and lfsr=LFSR_SEED, selects read phase, then → XFER.
- FINISH: done=1 for 1 cycle, busy=0, → IDLE.
- num_bursts=0: WAIT_INIT → FINISH with no Wishbone activity.
- Data pattern: Galois LFSR, x^32+x^22+x^2+x+1, shift-right form. wb_dat_o=lfsr[DW-1:0]. The read-phase expected value is the same sequence.
- Compare: only in the read phase of mode 2. On ack, wb_dat_i≠expected → err_cnt+1 (saturating). Mode 1 reads are not compared.
- Watchdog: counts cycles with stb=1 and ack=0; cleared on each ack.
  - On reaching TIMEOUT: timeout=1, cyc=stb=0, → FINISH. done still pulses.
- ack while stb=0: ignored.
- RESETN low mid-run: immediate abort; all outputs return to reset values.

Optional Feature:
Macro TGEN_ERR_LOG_EN.
- Defined: on the first mismatch of a run, first_err_addr/exp/got capture the address, expected data and received data. They hold until the next start, which clears them to 0.
- Undefined: the three ports are tied to 0 and no capture registers are built. err_cnt is unaffected.

Test Plan:
- DW=32, mode=2, base_addr=0x100, burst_len=4, num_bursts=2, slave acks every cycle → 8 writes to 0x100–0x107, exactly 1 idle cycle between bursts, 8 reads with the same data; err_cnt=0; 1 done pulse.
- Same run, slave corrupts read beat 3 (XOR 0x1) → err_cnt=1; with TGEN_ERR_LOG_EN, first_err_addr=0x103 and first_err_got=first_err_exp^1.
- sdr_init_done held 0 for 500 cycles after start → busy=1, no cyc until sdr_init_done=1; then the first write occurs within 2 cycles.
- Slave never acks, TIMEOUT=1024 → stb deasserts after 1024 cycles, timeout=1, done pulses, err_cnt=0.
- base_addr=2^AW−2, burst_len=4, mode=0 → addresses 3FFFFFE, 3FFFFFF, 0, 1; burst_len=0 → single beat; start pulsed mid-run is ignored.
- RESETN asserted mid-burst → cyc/stb/busy drop asynchronously; the next start after reset reproduces seed data 0x2468 on the first beat (DW=16).
